prbs_checker: RTL and testbench

//  Receive-side partner of the LFSR data source. Takes the recovered serial bit stream from the

---
 rtl/prbs_pkg.sv | 36 +++
 rtl/prbs_checker_if.sv | 33 +++
 rtl/prbs_lfsr_core.sv | 48 ++++
 rtl/prbs_checker.sv | 199 +++++++++++++++++++
 tb/tb_prbs_checker.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/prbs_pkg.sv
// -----------------------------------------------------------------------------
// prbs_pkg
// Shared types, constants and the prediction helper for the PRBS checker.
//   prbs_state_e       : checker state (SEARCH, LOCKED)
//   TAPS_W3/W7/W9      : default recurrence masks for common LFSR lengths
//   prbs_default_taps  : picks the default mask for a given LFSR length
//   prbs_pred          : next-bit prediction, ^(hist & taps)
// -----------------------------------------------------------------------------
package prbs_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } prbs_state_e;

    // Widest history the helper functions handle; callers zero-extend into it.
    localparam int PRED_MAX_W = 32;

    localparam logic [2:0] TAPS_W3 = 3'b101;
    localparam logic [6:0] TAPS_W7 = 7'b1100000;
    localparam logic [8:0] TAPS_W9 = 9'b100010000;

    function automatic logic [PRED_MAX_W-1:0] prbs_default_taps(input int lfsr_w);
        case (lfsr_w)
            7:       return PRED_MAX_W'(TAPS_W7);
            9:       return PRED_MAX_W'(TAPS_W9);
            default: return PRED_MAX_W'(TAPS_W3);
        endcase
    endfunction

    function automatic logic prbs_pred(input logic [PRED_MAX_W-1:0] hist,
                                       input logic [PRED_MAX_W-1:0] taps);
        return ^(hist & taps);
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// -----------------------------------------------------------------------------
// prbs_checker_if
// Bit-stream and status bundle of the PRBS checker.
//   en_i       : received bit valid strobe
//   data_i     : received bit
//   clr_i      : synchronous counter clear
//   locked_o   : checker synchronised to the sequence
//   err_o      : one-cycle pulse, checked bit mismatched
//   err_cnt_o  : saturating error count (LOCKED only)
//   bit_cnt_o  : saturating checked-bit count (LOCKED only)
// master drives the stream (demodulator side), slave is the checker.
// -----------------------------------------------------------------------------
interface prbs_checker_if #(
    parameter int CNT_W = 16
);
    logic             en_i;
    logic             data_i;
    logic             clr_i;
    logic             locked_o;
    logic             err_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic [CNT_W-1:0] bit_cnt_o;

    modport master (
        output en_i, data_i, clr_i,
        input  locked_o, err_o, err_cnt_o, bit_cnt_o
    );

    modport slave (
        input  en_i, data_i, clr_i,
        output locked_o, err_o, err_cnt_o, bit_cnt_o
    );
endinterface

// File: rtl/prbs_lfsr_core.sv
// -----------------------------------------------------------------------------
// prbs_lfsr_core
// History register of the local LFSR plus next-bit prediction.
//   clk, rst    : clock, asynchronous active-high reset
//   shift_i     : advance the history by one bit
//   sel_pred_i  : 1 = feed back own prediction (flywheel), 0 = feed received bit
//   data_i      : received bit
//   hist_o      : history, hist_o[0] is the newest bit
//   pred_o      : predicted next bit
// -----------------------------------------------------------------------------
module prbs_lfsr_core
    import prbs_pkg::*;
#(
    parameter int               LFSR_W = 3,
    parameter logic [LFSR_W-1:0] TAPS  = LFSR_W'(prbs_default_taps(LFSR_W))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_i,
    input  logic              sel_pred_i,
    input  logic              data_i,
    output logic [LFSR_W-1:0] hist_o,
    output logic              pred_o
);

    logic [LFSR_W-1:0] hist_q, hist_d;
    logic              fb;

    assign pred_o = prbs_pred(PRED_MAX_W'(hist_q), PRED_MAX_W'(TAPS));
    assign fb     = sel_pred_i ? pred_o : data_i;
    assign hist_o = hist_q;

    always_comb begin
        hist_d = hist_q;
        if (shift_i) begin
            hist_d = {hist_q[LFSR_W-2:0], fb};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
// Receive-side PRBS checker: self-synchronises a local LFSR to the recovered
// bit stream, then flags and counts bit errors for BER measurement.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : prbs_checker_if.slave (en_i, data_i, clr_i in;
//              locked_o, err_o, err_cnt_o, bit_cnt_o out)
// Build option: define PRBS_CHK_RESYNC_EN to enable loss-of-lock detection
// (LOSS_THR errors inside a block of WIN bits forces a resync). Without it
// LOCKED is held until reset.
//
// state  | meaning
// -------+-------------------------------------------------------------------
// SEARCH | history loads received bits; fill, then count consecutive matches
// LOCKED | local LFSR free-runs on its own prediction; errors flagged/counted
// -----------------------------------------------------------------------------
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int                LFSR_W   = 3,
    parameter logic [LFSR_W-1:0] TAPS     = LFSR_W'(prbs_default_taps(LFSR_W)),
    parameter int                LOCK_CNT = 8,
    parameter int                WIN      = 32,
    parameter int                LOSS_THR = 4,
    parameter int                CNT_W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    prbs_checker_if.slave  bus
);

    localparam int FILL_W  = $clog2(LFSR_W + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);

    if (LFSR_W < 2 || LOCK_CNT < 1 || LOSS_THR < 1 || LOSS_THR > WIN) begin : g_bad_params
        $error("prbs_checker: invalid parameter set");
    end

    prbs_state_e        state_q, state_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [LFSR_W-1:0]  hist;
    logic               pred;
    logic               mism;
    logic               fill_done;
    logic               hist_zero;
    logic               enter_lock;
    logic               lose_lock;

    prbs_lfsr_core #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .shift_i    (bus.en_i),
        .sel_pred_i (state_q == LOCKED),
        .data_i     (bus.data_i),
        .hist_o     (hist),
        .pred_o     (pred)
    );

    assign mism      = (bus.data_i != pred);
    assign fill_done = (fill_q == FILL_W'(LFSR_W));
    assign hist_zero = (hist == '0);

    // An all-zero history predicts zeros forever; never treat that as a match.
    assign enter_lock = (state_q == SEARCH) && bus.en_i && fill_done && !hist_zero &&
                        !mism && (match_cnt_q == MATCH_W'(LOCK_CNT - 1));

`ifdef PRBS_CHK_RESYNC_EN
    localparam int WB_W = $clog2(WIN + 1);
    localparam int WE_W = $clog2(LOSS_THR + 1);

    logic [WB_W-1:0] win_bits_q, win_bits_d;
    logic [WE_W-1:0] win_errs_q, win_errs_d;

    // Non-overlapping blocks of WIN checked bits; threshold beats block end.
    always_comb begin
        win_bits_d = win_bits_q;
        win_errs_d = win_errs_q;
        lose_lock  = 1'b0;
        if (enter_lock) begin
            win_bits_d = '0;
            win_errs_d = '0;
        end else if (state_q == LOCKED && bus.en_i) begin
            if (mism && win_errs_q == WE_W'(LOSS_THR - 1)) begin
                lose_lock  = 1'b1;
                win_bits_d = '0;
                win_errs_d = '0;
            end else if (win_bits_q == WB_W'(WIN - 1)) begin
                win_bits_d = '0;
                win_errs_d = '0;
            end else begin
                win_bits_d = win_bits_q + 1'b1;
                win_errs_d = win_errs_q + WE_W'(mism);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_bits_q <= '0;
            win_errs_q <= '0;
        end else begin
            win_bits_q <= win_bits_d;
            win_errs_q <= win_errs_d;
        end
    end
`else
    assign lose_lock = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        locked_d    = locked_q;
        err_d       = 1'b0;
        fill_d      = fill_q;
        match_cnt_d = match_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            SEARCH: begin
                if (bus.en_i) begin
                    if (!fill_done) begin
                        fill_d = fill_q + 1'b1;
                    end else if (mism || hist_zero) begin
                        match_cnt_d = '0;
                    end else if (enter_lock) begin
                        // The lock-completing bit itself is not counted.
                        state_d     = LOCKED;
                        locked_d    = 1'b1;
                        match_cnt_d = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (bus.en_i) begin
                    err_d = mism;
                    if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (mism && err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (lose_lock) begin
                        state_d     = SEARCH;
                        locked_d    = 1'b0;
                        fill_d      = '0;
                        match_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d  = SEARCH;
                locked_d = 1'b0;
            end
        endcase

        if (bus.clr_i) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEARCH;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            fill_q      <= '0;
            match_cnt_q <= '0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            fill_q      <= fill_d;
            match_cnt_q <= match_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.locked_o  = locked_q;
    assign bus.err_o     = err_q;
    assign bus.err_cnt_o = err_cnt_q;
    assign bus.bit_cnt_o = bit_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs_checker
// Directed bench for prbs_checker (LFSR_W=3, TAPS=3'b101, LOCK_CNT=8, WIN=32,
// LOSS_THR=4, CNT_W=16). Source LFSR seeded 3'b101 generates the stream.
// Expectations for the loss-of-lock case follow PRBS_CHK_RESYNC_EN.
// -----------------------------------------------------------------------------
module tb_prbs_checker;

    logic clk;
    logic rst;

    int n_chk;
    int n_err;

    logic [2:0] src_q;

    prbs_checker_if #(.CNT_W(16)) bus ();

    prbs_checker #(
        .LFSR_W   (3),
        .TAPS     (3'b101),
        .LOCK_CNT (8),
        .WIN      (32),
        .LOSS_THR (4),
        .CNT_W    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One valid bit from the source LFSR, optionally inverted, with optional clr.
    task automatic send(input logic flip, input logic clr);
        logic b;
        b     = src_q[0] ^ src_q[2];
        src_q = {src_q[1:0], b};
        bus.en_i   = 1'b1;
        bus.data_i = b ^ flip;
        bus.clr_i  = clr;
        @(posedge clk);
        #1;
        bus.en_i  = 1'b0;
        bus.clr_i = 1'b0;
    endtask

    task automatic send_raw(input logic d);
        bus.en_i   = 1'b1;
        bus.data_i = d;
        @(posedge clk);
        #1;
        bus.en_i = 1'b0;
    endtask

    task automatic idle(input int n, input logic clr);
        bus.en_i  = 1'b0;
        bus.clr_i = clr;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        bus.clr_i = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        idle(1, 1'b0);
    endtask

    logic err_seen;
    logic lock_seen;
    int   match_max;

    initial begin
        n_chk      = 0;
        n_err      = 0;
        src_q      = 3'b101;
        rst        = 1'b1;
        bus.en_i   = 1'b0;
        bus.data_i = 1'b0;
        bus.clr_i  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", 32'(bus.locked_o), 0);
        chk("rst_err", 32'(bus.err_o), 0);
        chk("rst_err_cnt", 32'(bus.err_cnt_o), 0);
        chk("rst_bit_cnt", 32'(bus.bit_cnt_o), 0);
        rst = 1'b0;
        idle(1, 1'b0);

        // 1: clean stream, lock after 3 fill + 8 matches
        for (int i = 1; i <= 10; i++) send(1'b0, 1'b0);
        chk("t1_locked_after10", 32'(bus.locked_o), 0);
        send(1'b0, 1'b0);
        chk("t1_locked_after11", 32'(bus.locked_o), 1);
        chk("t1_bit_cnt_at_lock", 32'(bus.bit_cnt_o), 0);
        err_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            send(1'b0, 1'b0);
            err_seen |= bus.err_o;
        end
        chk("t1_err_seen", 32'(err_seen), 0);
        chk("t1_bit_cnt", 32'(bus.bit_cnt_o), 100);
        chk("t1_err_cnt", 32'(bus.err_cnt_o), 0);

        // 2: single inverted bit
        send(1'b1, 1'b0);
        chk("t2_err_pulse", 32'(bus.err_o), 1);
        chk("t2_err_cnt", 32'(bus.err_cnt_o), 1);
        chk("t2_bit_cnt", 32'(bus.bit_cnt_o), 101);
        send(1'b0, 1'b0);
        chk("t2_err_after", 32'(bus.err_o), 0);
        chk("t2_err_cnt_hold", 32'(bus.err_cnt_o), 1);
        idle(1, 1'b0);
        chk("t2_err_idle", 32'(bus.err_o), 0);
        chk("t2_bit_cnt_idle", 32'(bus.bit_cnt_o), 102);

        // clr alone, lock kept
        idle(1, 1'b1);
        chk("clr_bit_cnt", 32'(bus.bit_cnt_o), 0);
        chk("clr_err_cnt", 32'(bus.err_cnt_o), 0);
        chk("clr_locked", 32'(bus.locked_o), 1);

        // 4: finish the current 32-bit block (102 checked so far), then 4 errors in one block
        for (int i = 0; i < 30; i++) send(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            send(1'b1, 1'b0);
            chk("t4_err_pulse", 32'(bus.err_o), 1);
            if (k < 3) begin
                chk("t4_locked_mid", 32'(bus.locked_o), 1);
                send(1'b0, 1'b0);
                send(1'b0, 1'b0);
            end
        end
`ifdef PRBS_CHK_RESYNC_EN
        chk("t4_locked_lost", 32'(bus.locked_o), 0);
`else
        chk("t4_locked_kept", 32'(bus.locked_o), 1);
`endif
        chk("t4_err_cnt", 32'(bus.err_cnt_o), 4);
        chk("t4_bit_cnt", 32'(bus.bit_cnt_o), 40);
        for (int i = 1; i <= 11; i++) begin
            send(1'b0, 1'b0);
`ifdef PRBS_CHK_RESYNC_EN
            if (i == 10) chk("t4_relock_10", 32'(bus.locked_o), 0);
`endif
        end
        chk("t4_locked_end", 32'(bus.locked_o), 1);
        chk("t4_err_cnt_end", 32'(bus.err_cnt_o), 4);
`ifdef PRBS_CHK_RESYNC_EN
        chk("t4_bit_cnt_end", 32'(bus.bit_cnt_o), 40);
`else
        chk("t4_bit_cnt_end", 32'(bus.bit_cnt_o), 51);
`endif

        // 6: async reset mid-LOCKED with an err pulse showing
        send(1'b1, 1'b0);
        chk("t6_err_before", 32'(bus.err_o), 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_locked", 32'(bus.locked_o), 0);
        chk("t6_rst_err", 32'(bus.err_o), 0);
        chk("t6_rst_err_cnt", 32'(bus.err_cnt_o), 0);
        chk("t6_rst_bit_cnt", 32'(bus.bit_cnt_o), 0);
        idle(1, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) send(1'b0, 1'b0);
        chk("t6_relock_10", 32'(bus.locked_o), 0);
        send(1'b0, 1'b0);
        chk("t6_relock_11", 32'(bus.locked_o), 1);
        send(1'b0, 1'b0);
        chk("t6_bit_cnt", 32'(bus.bit_cnt_o), 1);

        // 3: all-zero input never locks
        pulse_rst();
        lock_seen = 1'b0;
        match_max = 0;
        for (int i = 0; i < 50; i++) begin
            send_raw(1'b0);
            lock_seen |= bus.locked_o;
            if (int'(dut.match_cnt_q) > match_max) match_max = int'(dut.match_cnt_q);
        end
        chk("t3_lock_seen", 32'(lock_seen), 0);
        chk("t3_match_max", 32'(match_max), 0);
        chk("t3_bit_cnt", 32'(bus.bit_cnt_o), 0);

        // 5: en 1-in-3, then clr concurrent with an error
        pulse_rst();
        for (int i = 1; i <= 11; i++) begin
            send(1'b0, 1'b0);
            if (i == 10) chk("t5_locked_10", 32'(bus.locked_o), 0);
            if (i == 11) chk("t5_locked_11", 32'(bus.locked_o), 1);
            idle(2, 1'b0);
            if (i == 10) chk("t5_locked_10_idle", 32'(bus.locked_o), 0);
        end
        send(1'b0, 1'b0);
        chk("t5_bit_cnt", 32'(bus.bit_cnt_o), 1);
        idle(2, 1'b0);
        send(1'b1, 1'b1);
        chk("t5_clr_err_pulse", 32'(bus.err_o), 1);
        chk("t5_clr_err_cnt", 32'(bus.err_cnt_o), 0);
        chk("t5_clr_bit_cnt", 32'(bus.bit_cnt_o), 0);
        idle(1, 1'b0);
        chk("t5_err_idle", 32'(bus.err_o), 0);
        send(1'b0, 1'b0);
        chk("t5_bit_cnt_after", 32'(bus.bit_cnt_o), 1);
        chk("t5_err_cnt_after", 32'(bus.err_cnt_o), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
